// File: rtl/shift_exec_stage.sv
// shift_exec_stage: execute-stage wrapper around an external combinational
// MIPS shifter (SLL/SRL/SRA/SLLV/SRLV/SRAV).
//   S1 latches the decoded operands and drives the shifter.
//   S2 registers the shifter result toward the register-file write port.
// Both sides use valid/ready. With an open output the stage accepts one
// instruction per cycle.
// Optional feature: define SHIFT_EXEC_PERF_EN to enable the retired-shift
// counter. When it is undefined, shift_cnt is tied to zero and no counter
// flops are built.
module shift_exec_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            in_funct,
  input  logic [4:0]            in_shamt,
  input  logic [DATA_WIDTH-1:0] in_rs,
  input  logic [DATA_WIDTH-1:0] in_rt,
  input  logic [4:0]            in_rd,
  output logic [DATA_WIDTH-1:0] sh_A,
  output logic [4:0]            sh_B,
  output logic [1:0]            sh_op,
  input  logic [DATA_WIDTH-1:0] sh_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_wen,
  output logic [4:0]            out_waddr,
  output logic [DATA_WIDTH-1:0] out_wdata,
  output logic [31:0]           shift_cnt
);

  // Only rs[4:0] can supply a shift amount; the upper bits are dropped here.
  logic unused_rs_hi;
  assign unused_rs_hi = ^in_rs[DATA_WIDTH-1:5];

  // Decoded operands, computed from decode's current outputs.
  logic                  dec_legal;
  logic [1:0]            dec_op;
  logic [DATA_WIDTH-1:0] dec_a;
  logic [4:0]            dec_b;

  // S1 registers.
  logic                  v1_q, v1_d;
  logic                  s1_legal_q, s1_legal_d;
  logic [1:0]            s1_op_q, s1_op_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [4:0]            s1_b_q, s1_b_d;
  logic [4:0]            s1_rd_q, s1_rd_d;

  // S2 registers.
  logic                  v2_q, v2_d;
  logic                  s2_wen_q, s2_wen_d;
  logic [4:0]            s2_waddr_q, s2_waddr_d;
  logic [DATA_WIDTH-1:0] s2_wdata_q, s2_wdata_d;

  logic accept;
  logic s2_take;

  // Handshake. S2 can take a new entry when it is empty or is draining
  // this cycle, and S1 can refill in the same cycle it moves forward.
  assign s2_take  = ~v2_q | out_ready;
  assign in_ready = ~v1_q | s2_take;
  assign accept   = in_valid & in_ready;

  // Decode funct. Illegal encodings produce a zero-operand entry that
  // still flows through the pipe but never writes.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = 2'b00;
    dec_a     = '0;
    dec_b     = '0;
    case (in_funct)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: dec_legal = 1'b1;
      default:                                  dec_legal = 1'b0;
    endcase
    if (dec_legal) begin
      dec_op = in_funct[1:0];
      dec_a  = in_rt;
      dec_b  = in_funct[2] ? in_rs[4:0] : in_shamt;
    end
  end

  // S1 next state: load on accept, otherwise hold; valid clears once the
  // entry has moved forward.
  always_comb begin
    v1_d       = v1_q;
    s1_legal_d = s1_legal_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_rd_d    = s1_rd_q;
    if (accept) begin
      v1_d       = 1'b1;
      s1_legal_d = dec_legal;
      s1_op_d    = dec_op;
      s1_a_d     = dec_a;
      s1_b_d     = dec_b;
      s1_rd_d    = in_rd;
    end else if (s2_take) begin
      v1_d = 1'b0;
    end
  end

  // S1 state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q       <= 1'b0;
      s1_legal_q <= 1'b0;
      s1_op_q    <= 2'b00;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_rd_q    <= '0;
    end else begin
      v1_q       <= v1_d;
      s1_legal_q <= s1_legal_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_rd_q    <= s1_rd_d;
    end
  end

  // The shifter sees only registered operands, so there is no
  // combinational path from decode to the shifter.
  assign sh_A  = s1_a_q;
  assign sh_B  = s1_b_q;
  assign sh_op = s1_op_q;

  // S2 next state. While out_valid is stalled, S2 holds, which keeps the
  // writeback outputs stable.
  always_comb begin
    v2_d       = v2_q;
    s2_wen_d   = s2_wen_q;
    s2_waddr_d = s2_waddr_q;
    s2_wdata_d = s2_wdata_q;
    if (s2_take) begin
      v2_d = v1_q;
      if (v1_q) begin
        s2_wen_d   = s1_legal_q & (s1_rd_q != 5'd0);
        s2_waddr_d = s1_rd_q;
        s2_wdata_d = s1_legal_q ? sh_result : '0;
      end
    end
  end

  // S2 state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q       <= 1'b0;
      s2_wen_q   <= 1'b0;
      s2_waddr_q <= '0;
      s2_wdata_q <= '0;
    end else begin
      v2_q       <= v2_d;
      s2_wen_q   <= s2_wen_d;
      s2_waddr_q <= s2_waddr_d;
      s2_wdata_q <= s2_wdata_d;
    end
  end

  assign out_valid = v2_q;
  assign out_wen   = s2_wen_q;
  assign out_waddr = s2_waddr_q;
  assign out_wdata = s2_wdata_q;

`ifdef SHIFT_EXEC_PERF_EN
  // Legality must travel to S2 because out_wen cannot tell an rd=0 shift
  // from an illegal one.
  logic        s2_legal_q, s2_legal_d;
  logic [31:0] cnt_q, cnt_d;

  // Track S2 legality and count legal retirements. The counter wraps freely.
  always_comb begin
    s2_legal_d = s2_legal_q;
    cnt_d      = cnt_q;
    if (s2_take && v1_q) s2_legal_d = s1_legal_q;
    if (v2_q && out_ready && s2_legal_q) cnt_d = cnt_q + 32'd1;
  end

  // Counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_legal_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s2_legal_q <= s2_legal_d;
      cnt_q      <= cnt_d;
    end
  end

  assign shift_cnt = cnt_q;
`else
  assign shift_cnt = '0;
`endif

endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage. It includes a behavioural shifter and a
// queue-based scoreboard of expected writeback entries.
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [4:0]  in_rd;
  logic [31:0] sh_A;
  logic [4:0]  sh_B;
  logic [1:0]  sh_op;
  logic [31:0] sh_result;
  logic        out_valid;
  logic        out_ready;
  logic        out_wen;
  logic [4:0]  out_waddr;
  logic [31:0] out_wdata;
  logic [31:0] shift_cnt;

  shift_exec_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_shamt(in_shamt), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .sh_A(sh_A), .sh_B(sh_B), .sh_op(sh_op), .sh_result(sh_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wen(out_wen), .out_waddr(out_waddr), .out_wdata(out_wdata),
    .shift_cnt(shift_cnt)
  );

  always #5 clk = ~clk;

  // External combinational shifter.
  logic signed [31:0] sh_A_s;
  assign sh_A_s = sh_A;
  always_comb begin
    case (sh_op)
      2'b00:   sh_result = sh_A << sh_B;
      2'b10:   sh_result = sh_A >> sh_B;
      2'b11:   sh_result = sh_A_s >>> sh_B;
      default: sh_result = 32'h0;
    endcase
  end

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        legal;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur_exp;
  int          checks = 0;
  int          failures = 0;
  logic        acc_prev = 1'b0;
  logic        last_acc;
  logic [31:0] cnt_model = 32'h0;
  logic [5:0]  flist [9] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h20};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [5:0] f, input logic [4:0] sa,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [4:0] rd);
    exp_t e;
    logic [4:0] amt;
    logic signed [31:0] srt;
    srt     = rt;
    amt     = f[2] ? rs[4:0] : sa;
    e.legal = (f == 6'h00) || (f == 6'h02) || (f == 6'h03) ||
              (f == 6'h04) || (f == 6'h06) || (f == 6'h07);
    case (f[1:0])
      2'b00:   e.wdata = rt << amt;
      2'b10:   e.wdata = rt >> amt;
      default: e.wdata = srt >>> amt;
    endcase
    if (!e.legal) e.wdata = 32'h0;
    e.wen   = e.legal && (rd != 5'd0);
    e.waddr = rd;
    return e;
  endfunction

  // Drive an instruction together with its hand-computed expected entry.
  task automatic set_in(input logic [5:0] f, input logic [4:0] sa, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [4:0] rd,
                        input logic [31:0] wd, input logic wen, input logic legal);
    in_funct = f; in_shamt = sa; in_rs = rs; in_rt = rt; in_rd = rd;
    cur_exp.wen = wen; cur_exp.waddr = rd; cur_exp.wdata = wd; cur_exp.legal = legal;
  endtask

  // One cycle: check outputs against the scoreboard at negedge+1, update
  // the scoreboard for the coming posedge, and advance to the next negedge.
  task automatic tick();
    int   n;
    logic exp_ov, exp_ir, hs;
    #1;
    n      = sb.size();
    exp_ir = (n < 2) || out_ready;
    exp_ov = (n == 2) || (n == 1 && !acc_prev);
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      check("out_wen", 32'(out_wen), 32'(sb[0].wen));
      check("out_waddr", 32'(out_waddr), 32'(sb[0].waddr));
      check("out_wdata", out_wdata, sb[0].wdata);
    end
    check("shift_cnt", shift_cnt, cnt_model);
    hs       = exp_ov && out_ready;
    last_acc = in_valid && exp_ir;
    if (hs) begin
`ifdef SHIFT_EXEC_PERF_EN
      if (sb[0].legal) cnt_model = cnt_model + 32'd1;
`endif
      void'(sb.pop_front());
    end
    if (last_acc) sb.push_back(cur_exp);
    acc_prev = last_acc;
    @(negedge clk);
  endtask

  task automatic drain();
    int guard = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() > 0 && guard < 20) begin
      tick();
      guard++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_in(6'h00, 5'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    // Values held while reset is asserted.
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_wen", 32'(out_wen), 32'd0);
    check("rst_out_waddr", 32'(out_waddr), 32'd0);
    check("rst_out_wdata", out_wdata, 32'h0);
    check("rst_shift_cnt", shift_cnt, 32'h0);
    check("rst_sh_A", sh_A, 32'h0);
    check("rst_sh_B", 32'(sh_B), 32'd0);
    check("rst_sh_op", 32'(sh_op), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // SRA by immediate 4.
    set_in(6'h03, 5'd4, 32'h0, 32'h80000000, 5'd5, 32'hF8000000, 1'b1, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();

    // SRLV: amount comes from rs[4:0] (0x24 -> 4), and shamt is ignored.
    set_in(6'h06, 5'd9, 32'h00000024, 32'h000000F0, 5'd3, 32'h0000000F, 1'b1, 1'b1);
    in_valid = 1'b1;
    tick();
    drain();

    // Back-to-back SLL 1,2,3 with the output stalled for three cycles.
    out_ready = 1'b0;
    set_in(6'h00, 5'd1, 32'h0, 32'h1, 5'd10, 32'h2, 1'b1, 1'b1);
    in_valid = 1'b1;
    tick();
    set_in(6'h00, 5'd2, 32'h0, 32'h1, 5'd11, 32'h4, 1'b1, 1'b1);
    tick();
    set_in(6'h00, 5'd3, 32'h0, 32'h1, 5'd12, 32'h8, 1'b1, 1'b1);
    tick();
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b1;
    tick();
    drain();

    // Illegal funct: the entry flows but does not write.
    set_in(6'h01, 5'd3, 32'h0, 32'hFFFFFFFF, 5'd7, 32'h0, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    drain();

    // SLL to rd=0: no write, but the data is still produced.
    set_in(6'h00, 5'd3, 32'h0, 32'h5, 5'd0, 32'h28, 1'b0, 1'b1);
    in_valid = 1'b1;
    tick();
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 60; i++) begin
      logic [5:0]  f;
      logic [4:0]  sa, rd;
      logic [31:0] rs, rt;
      f  = flist[$urandom_range(0, 8)];
      sa = 5'($urandom);
      rd = 5'($urandom);
      rs = $urandom;
      rt = $urandom;
      in_funct = f; in_shamt = sa; in_rs = rs; in_rt = rt; in_rd = rd;
      cur_exp   = model(f, sa, rs, rt, rd);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    // Reset with both stages full.
    out_ready = 1'b0;
    set_in(6'h02, 5'd1, 32'h0, 32'h10, 5'd4, 32'h8, 1'b1, 1'b1);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_shift_cnt", shift_cnt, 32'h0);
    sb.delete();
    cnt_model = 32'h0;
    acc_prev  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Operation resumes normally after reset.
    set_in(6'h07, 5'd0, 32'h0000001F, 32'h80000000, 5'd9, 32'hFFFFFFFF, 1'b1, 1'b1);
    in_valid = 1'b1;
    tick();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
